// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, inst} entries.
// Define INST_QUEUE_BYPASS_EN to forward a fetch group straight to the head while the queue is empty.
module inst_queue #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_flush,
    input  logic                               i_hold,
    input  logic                               i_push_valid,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]   i_push_cnt,
    input  logic [31:0]                        i_push_pc,
    input  logic [32*FETCH_WIDTH-1:0]          i_push_inst,
    output logic                               o_push_ready,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   i_pop_cnt,
    output logic [ISSUE_WIDTH-1:0]             o_head_valid,
    output logic [32*ISSUE_WIDTH-1:0]          o_head_inst,
    output logic [32*ISSUE_WIDTH-1:0]          o_head_pc,
    output logic [$clog2(DEPTH+1)-1:0]         o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_push_acc;
    logic          w_bypass;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_avail;
    logic [CW-1:0] w_pop_req;
    logic [CW-1:0] w_eff_pop;

    // Ready looks only at the registered count so fetch never sees a path from decode's pop.
    assign o_push_ready = (CW'(DEPTH) - r_count) >= CW'(FETCH_WIDTH);
    assign w_push_acc   = i_push_valid & o_push_ready;
    assign w_push_n     = w_push_acc ? CW'(i_push_cnt) : '0;
    assign o_count      = r_count;

`ifdef INST_QUEUE_BYPASS_EN
    localparam int unsigned PADW = FETCH_WIDTH + ISSUE_WIDTH;
    logic [32*PADW-1:0] w_push_pad;
    assign w_push_pad = {{(32*ISSUE_WIDTH){1'b0}}, i_push_inst};
    assign w_bypass   = (r_count == '0) & ~i_flush & w_push_acc;
`else
    assign w_bypass   = 1'b0;
`endif

    assign w_avail   = w_bypass ? w_push_n : r_count;
    assign w_pop_req = CW'(i_pop_cnt);
    assign w_eff_pop = i_hold ? '0 : ((w_pop_req > w_avail) ? w_avail : w_pop_req);

    always_comb begin
        o_head_valid = '0;
        o_head_inst  = '0;
        o_head_pc    = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
`ifdef INST_QUEUE_BYPASS_EN
            if (w_bypass) begin
                if (i < int'(i_push_cnt)) begin
                    o_head_valid[i]         = 1'b1;
                    o_head_inst[32*i +: 32] = w_push_pad[32*i +: 32];
                    o_head_pc[32*i +: 32]   = i_push_pc + 32'(4 * i);
                end
            end else
`endif
            if (i < int'(r_count)) begin
                o_head_valid[i]         = 1'b1;
                o_head_inst[32*i +: 32] = r_mem_inst[r_rd_ptr + PW'(i)];
                o_head_pc[32*i +: 32]   = r_mem_pc[r_rd_ptr + PW'(i)];
            end
        end
    end

    // A bypassed group is still written in full; rd_ptr skips over the slots consumed at once.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PW'(w_eff_pop);
            r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            r_count  <= r_count + w_push_n - w_eff_pop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_push_acc) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (j < int'(i_push_cnt)) begin
                    r_mem_inst[r_wr_ptr + PW'(j)] <= i_push_inst[32*j +: 32];
                    r_mem_pc[r_wr_ptr + PW'(j)]   <= i_push_pc + 32'(4 * j);
                end
            end
        end
    end

    a_pop_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
        (!i_flush && !i_hold) |-> (w_pop_req <= w_avail));

    a_push_cnt_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        i_push_valid |-> (i_push_cnt != '0 && int'(i_push_cnt) <= FETCH_WIDTH));

endmodule
